// File: rtl/arm_control_fsm.sv
// arm_control_fsm: multicycle control unit for the ARM datapath.
// Sequences fetch, decode and execute for data-processing, load/store and
// branch instructions. Outputs are a Moore decode of the registered state and ir.
// Optional feature: define MEM_TIMEOUT_EN to abort a memory wait that lasts
// MEM_TIMEOUT cycles without moc (ABORT state, one-cycle err pulse, fetch retried).
module arm_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        cond_pass,
    input  logic        moc,
    output logic        ir_load,
    output logic        pc_load,
    output logic        pc_sel,
    output logic        mar_load,
    output logic        mar_sel,
    output logic        mem_en,
    output logic        mem_rw,
    output logic        rf_we,
    output logic        rd_lr,
    output logic        rd_src,
    output logic        flags_we,
    output logic [3:0]  alu_op,
    output logic [3:0]  state,
    output logic        err
);

    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_RESET      = 4'd0,
        ST_FETCH      = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_FETCH_LOAD = 4'd3,
        ST_DECODE     = 4'd4,
        ST_EXEC_DP    = 4'd5,
        ST_MEM_ADDR   = 4'd6,
        ST_MEM_WAIT   = 4'd7,
        ST_MEM_WB     = 4'd8,
        ST_BRANCH     = 4'd9
`ifdef MEM_TIMEOUT_EN
        ,ST_ABORT     = 4'd10
`endif
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    // The timeout counter must be able to represent MEM_TIMEOUT-1
    if ((64'd1 << CNT_W) <= 64'(MEM_TIMEOUT)) begin : g_cfg_check
        $error("arm_control_fsm: 2**CNT_W must exceed MEM_TIMEOUT");
    end

    state_e state_q;
    state_e state_next;
    logic   tmo_c;

    // Fields of ir not consulted by the control decode
    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[19:8], ir[6:5], ir[3:0]};

    assign state = state_q;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             in_wait_c;
    logic             enter_wait_c;

    assign in_wait_c    = (state_q == ST_FETCH_WAIT) || (state_q == ST_MEM_WAIT);
    assign enter_wait_c = (state_next != state_q) &&
                          ((state_next == ST_FETCH_WAIT) || (state_next == ST_MEM_WAIT));
    assign tmo_c        = in_wait_c && !moc && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // Wait-cycle counter: cleared on entry to a wait state, saturating count of moc-less cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (enter_wait_c) begin
            cnt_q <= '0;
        end else if (in_wait_c && !moc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign tmo_c = 1'b0;
    assign err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_next = state_q;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_sel     = 1'b0;
        mar_load   = 1'b0;
        mar_sel    = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        rf_we      = 1'b0;
        rd_lr      = 1'b0;
        rd_src     = 1'b0;
        flags_we   = 1'b0;
        alu_op     = 4'b0000;
`ifdef MEM_TIMEOUT_EN
        err        = 1'b0;
`endif
        case (state_q)
            ST_RESET: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mar_load   = 1'b1;
                state_next = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                if (moc) begin
                    state_next = ST_FETCH_LOAD;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_c) begin
                    state_next = ST_ABORT;
                end
`endif
            end
            ST_FETCH_LOAD: begin
                ir_load    = 1'b1;
                pc_load    = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!cond_pass) begin
                    state_next = ST_FETCH;
                end else begin
                    case (ir[27:25])
                        3'b000:  state_next = (ir[4] && ir[7]) ? ST_MEM_ADDR : ST_EXEC_DP;
                        3'b001:  state_next = ST_EXEC_DP;
                        3'b010,
                        3'b011:  state_next = ST_MEM_ADDR;
                        3'b101:  state_next = ST_BRANCH;
                        default: state_next = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC_DP: begin
                alu_op     = ir[24:21];
                flags_we   = ir[20];
                rf_we      = (ir[24:23] != 2'b10);
                state_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_op     = ir[23] ? ALU_ADD : ALU_SUB;
                mar_load   = 1'b1;
                mar_sel    = 1'b1;
                state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                mem_en = 1'b1;
                mem_rw = ir[20];
                if (moc) begin
                    state_next = ir[20] ? ST_MEM_WB : ST_FETCH;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_c) begin
                    state_next = ST_ABORT;
                end
`endif
            end
            ST_MEM_WB: begin
                rf_we      = 1'b1;
                rd_src     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_load    = 1'b1;
                pc_sel     = 1'b1;
                alu_op     = ALU_ADD;
                rf_we      = ir[24];
                rd_lr      = ir[24];
                state_next = ST_FETCH;
            end
`ifdef MEM_TIMEOUT_EN
            ST_ABORT: begin
                err        = 1'b1;
                state_next = ST_FETCH;
            end
`endif
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_arm_control_fsm.sv
// Testbench for arm_control_fsm: instruction-level reference model plus
// directed literal checks and randomized instruction/moc/cond_pass stimulus.
// Honours MEM_TIMEOUT_EN the same way as the design.
module tb_arm_control_fsm;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        cond_pass = 1'b0;
    logic        moc = 1'b0;
    logic        ir_load, pc_load, pc_sel, mar_load, mar_sel, mem_en, mem_rw;
    logic        rf_we, rd_lr, rd_src, flags_we, err;
    logic [3:0]  alu_op, state;

    int n_tests = 0;
    int n_fail  = 0;

    arm_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .cond_pass(cond_pass), .moc(moc),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
        .mar_load(mar_load), .mar_sel(mar_sel), .mem_en(mem_en), .mem_rw(mem_rw),
        .rf_we(rf_we), .rd_lr(rd_lr), .rd_src(rd_src), .flags_we(flags_we),
        .alu_op(alu_op), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    // Phase numbers as published for the debug state port
    localparam int P_RESET = 0, P_FETCH = 1, P_FWAIT = 2, P_FLOAD = 3, P_DECODE = 4,
                   P_DP = 5, P_MADDR = 6, P_MWAIT = 7, P_MWB = 8, P_BRANCH = 9, P_ABORT = 10;
    localparam int K_DP = 0, K_MEM = 1, K_BR = 2, K_NOP = 3;

    // Instruction kind from the opcode class bits
    function automatic int kind_of(input logic [31:0] i);
        logic [2:0] cls;
        cls = i[27:25];
        if (cls == 3'd0) return (i[4] && i[7]) ? K_MEM : K_DP;
        if (cls == 3'd1) return K_DP;
        if (cls == 3'd2 || cls == 3'd3) return K_MEM;
        if (cls == 3'd5) return K_BR;
        return K_NOP;
    endfunction

    // Expected output bundle {ir_load,pc_load,pc_sel,mar_load,mar_sel,mem_en,mem_rw,
    // rf_we,rd_lr,rd_src,flags_we,alu_op,state,err} for a phase and instruction
    function automatic logic [19:0] expect_out(input int p, input logic [31:0] i);
        logic [10:0] ctl;
        logic [3:0]  op;
        logic        e;
        ctl = '0; op = 4'd0; e = 1'b0;
        if (p == P_FETCH)  ctl = 11'b000_1000_0000;
        if (p == P_FWAIT)  ctl = 11'b000_0011_0000;
        if (p == P_FLOAD)  ctl = 11'b110_0000_0000;
        if (p == P_DP) begin
            op  = i[24:21];
            ctl = {7'b0, (i[24:23] == 2'b10) ? 1'b0 : 1'b1, 2'b00, i[20]};
        end
        if (p == P_MADDR) begin
            op  = i[23] ? 4'd4 : 4'd2;
            ctl = 11'b000_1100_0000;
        end
        if (p == P_MWAIT)  ctl = {5'b00000, 1'b1, i[20], 4'b0000};
        if (p == P_MWB)    ctl = 11'b000_0000_1010;
        if (p == P_BRANCH) begin
            op  = 4'd4;
            ctl = {3'b011, 4'b0000, i[24], i[24], 2'b00};
        end
        if (p == P_ABORT)  e = 1'b1;
        return {ctl, op, 4'(p), e};
    endfunction

    // Reference model: phase and count of moc-less cycles in the current wait
    int m_phase = 0;
    int m_waited = 0;

    function automatic int model_next(input int p, input logic [31:0] i, input logic c,
                                      input logic m, input int waited);
        bit expired;
`ifdef MEM_TIMEOUT_EN
        expired = !m && (waited == MEM_TIMEOUT - 1);
`else
        expired = 1'b0;
`endif
        if (p == P_FWAIT || p == P_MWAIT) begin
            if (m) return (p == P_FWAIT) ? P_FLOAD : (i[20] ? P_MWB : P_FETCH);
            return expired ? P_ABORT : p;
        end
        if (p == P_DECODE) begin
            if (!c) return P_FETCH;
            case (kind_of(i))
                K_DP:    return P_DP;
                K_MEM:   return P_MADDR;
                K_BR:    return P_BRANCH;
                default: return P_FETCH;
            endcase
        end
        if (p == P_RESET)  return P_FETCH;
        if (p == P_FETCH)  return P_FWAIT;
        if (p == P_FLOAD)  return P_DECODE;
        if (p == P_MADDR)  return P_MWAIT;
        return P_FETCH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= P_RESET;
            m_waited <= 0;
        end else begin
            int nxt;
            nxt = model_next(m_phase, ir, cond_pass, moc, m_waited);
            m_phase <= nxt;
            if (nxt != m_phase && (nxt == P_FWAIT || nxt == P_MWAIT))
                m_waited <= 0;
            else if ((m_phase == P_FWAIT || m_phase == P_MWAIT) && !moc && m_waited < 15)
                m_waited <= m_waited + 1;
        end
    end

    logic [19:0] act_vec;
    assign act_vec = {ir_load, pc_load, pc_sel, mar_load, mar_sel, mem_en, mem_rw,
                      rf_we, rd_lr, rd_src, flags_we, alu_op, state, err};

    bit compare_on = 1'b0;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        #2;
        if (compare_on) begin
            logic [19:0] exp_vec;
            exp_vec = expect_out(m_phase, ir);
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t ir=%h got=%h want=%h", $time, ir, act_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic c, input logic m);
        @(negedge clk);
        ir = i; cond_pass = c; moc = m;
        #3;
    endtask

    // Reset, then release so the next edge enters FETCH
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // FETCH, FETCH_WAIT (moc=1), FETCH_LOAD with phase checks
    task automatic fetch(input logic [31:0] i, input string tag);
        drive(i, 1'b1, 1'b1); chk({tag, "_fetch"}, int'(state), 1); chk({tag, "_mar_load"}, int'(mar_load), 1);
        drive(i, 1'b1, 1'b1); chk({tag, "_fwait"}, int'(state), 2); chk({tag, "_mem_rw"}, int'(mem_rw), 1);
        drive(i, 1'b1, 1'b1); chk({tag, "_fload"}, int'(state), 3); chk({tag, "_ir_load"}, int'(ir_load), 1);
    endtask

    localparam logic [31:0] I_ADD = 32'hE0810002;
    localparam logic [31:0] I_CMP = 32'hE1510002;
    localparam logic [31:0] I_LDR = 32'hE5912004;
    localparam logic [31:0] I_BL  = 32'hEB000010;
    localparam logic [31:0] I_BEQ = 32'h0A000010;

    initial begin
        int st[25];
        int run;
        int errs;
        #1;
        compare_on = 1'b1;
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'(act_vec), 0);

        // ADD
        do_reset();
        #3; chk("release_state", int'(state), 0);
        fetch(I_ADD, "add");
        drive(I_ADD, 1'b1, 1'b0); chk("add_decode", int'(state), 4); chk("add_decode_quiet", int'(act_vec[19:9]), 0);
        drive(I_ADD, 1'b1, 1'b0); chk("add_exec", int'(state), 5);
        chk("add_alu_op", int'(alu_op), 4); chk("add_rf_we", int'(rf_we), 1); chk("add_flags_we", int'(flags_we), 0);

        // CMP
        fetch(I_CMP, "cmp");
        drive(I_CMP, 1'b1, 1'b0);
        drive(I_CMP, 1'b1, 1'b0); chk("cmp_exec", int'(state), 5);
        chk("cmp_alu_op", int'(alu_op), 10); chk("cmp_rf_we", int'(rf_we), 0); chk("cmp_flags_we", int'(flags_we), 1);

        // LDR with moc delayed three cycles
        fetch(I_LDR, "ldr");
        drive(I_LDR, 1'b1, 1'b0);
        drive(I_LDR, 1'b1, 1'b0); chk("ldr_addr", int'(state), 6); chk("ldr_alu_add", int'(alu_op), 4);
        for (int k = 0; k < 3; k++) begin
            drive(I_LDR, 1'b1, 1'b0); chk("ldr_wait", int'(state), 7); chk("ldr_wait_rw", int'(mem_rw), 1);
        end
        drive(I_LDR, 1'b1, 1'b1); chk("ldr_wait_last", int'(state), 7);
        drive(I_LDR, 1'b1, 1'b0); chk("ldr_wb", int'(state), 8);
        chk("ldr_wb_rf_we", int'(rf_we), 1); chk("ldr_wb_rd_src", int'(rd_src), 1);

        // BL, then a condition-failed branch
        fetch(I_BL, "bl");
        drive(I_BL, 1'b1, 1'b0);
        drive(I_BL, 1'b1, 1'b0); chk("bl_branch", int'(state), 9);
        chk("bl_pc", int'({pc_load, pc_sel}), 3); chk("bl_link", int'({rf_we, rd_lr}), 3);
        fetch(I_BEQ, "beq");
        drive(I_BEQ, 1'b0, 1'b0); chk("beq_decode", int'(state), 4); chk("beq_no_pc_load", int'(pc_load), 0);
        drive(I_BEQ, 1'b0, 1'b0); chk("beq_refetch", int'(state), 1);

        // Asynchronous reset in the middle of MEM_WAIT
        drive(I_LDR, 1'b1, 1'b1); drive(I_LDR, 1'b1, 1'b1);
        drive(I_LDR, 1'b1, 1'b0); drive(I_LDR, 1'b1, 1'b0);
        drive(I_LDR, 1'b1, 1'b0); drive(I_LDR, 1'b1, 1'b0); chk("pre_rst_mwait", int'(state), 7);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_state", int'(state), 0); chk("async_rst_outputs", int'(act_vec), 0);
        @(negedge clk); rst_n = 1'b1;
        drive(I_LDR, 1'b1, 1'b0); chk("rst_release_1", int'(state), 1);
        drive(I_LDR, 1'b1, 1'b0); chk("rst_release_2", int'(state), 2);

        // moc held low in FETCH_WAIT
        do_reset();
        errs = 0;
        for (int k = 0; k < 25; k++) begin
            drive(I_ADD, 1'b1, 1'b0);
            st[k] = int'(state);
            if (err) errs++;
        end
        run = 0;
        for (int k = 1; k < 25; k++) begin
            if (st[k] != 2) break;
            run++;
        end
`ifdef MEM_TIMEOUT_EN
        chk("timeout_wait_cycles", run, 15);
        chk("timeout_abort", st[16], 10);
        chk("timeout_refetch", st[17], 1);
        chk("timeout_err_pulses", errs, 1);
`else
        chk("hold_wait_cycles", run, 24);
        chk("hold_no_err", errs, 0);
`endif

        // Randomized instruction stream with occasional mid-cycle resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            int k;
            r = $urandom;
            k = $urandom_range(0, 5);
            case (k)
                0: begin r[27:25] = 3'b000; r[4] = 1'b0; end
                1: r[27:25] = 3'b001;
                2: r[27:25] = 3'($urandom_range(2, 3));
                3: r[27:25] = 3'b101;
                4: begin r[27:25] = 3'b000; r[4] = 1'b1; r[7] = 1'b1; end
                default: r[27:25] = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'($urandom_range(6, 7));
            endcase
            if (!rst_n) begin
                @(negedge clk);
                rst_n = 1'b1;
                #0;
            end
            drive(r, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        #4;
        compare_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
